// File: rtl/fir_tap_sequencer.sv
// Sample-history sequencer for the equalizer: writes each new sample into a circular
// RAM buffer, then streams the NumTaps newest entries (newest first) to the MAC stage.
// Optional build macro CLEAR_ON_RESET_EN zero-fills the whole history after reset.
module fir_tap_sequencer #(
   parameter int AddrWidth = 9,
   parameter int DataWidth = 16,
   parameter int MaxAddr   = 511,
   parameter int NumTaps   = 64,
   parameter int TapWidth  = 6
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [DataWidth-1:0] SampleIn,
   input  logic                 SampleValid,
   output logic                 SampleReady,
   output logic [DataWidth-1:0] TapData,
   output logic [TapWidth-1:0]  TapIndex,
   output logic                 TapValid,
   output logic                 TapLast,
   input  logic                 TapReady,
   output logic                 Wr,
   output logic [AddrWidth-1:0] Addr,
   output logic [DataWidth-1:0] RAMIn,
   input  logic [DataWidth-1:0] RAMOut
);

   localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(MaxAddr);
   localparam logic [AddrWidth-1:0] LastTap  = AddrWidth'(NumTaps - 1);
   localparam logic [AddrWidth:0]   DepthExt = (AddrWidth + 1)'(MaxAddr + 1);

`ifdef CLEAR_ON_RESET_EN
   typedef enum logic [1:0] {IDLE, WRITE, READ, CLEAR} state_t;
`else
   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
`endif

   state_t state, nextState;

   logic [AddrWidth-1:0] headPtr;
   logic [AddrWidth-1:0] tapCount;
   logic [AddrWidth-1:0] readAddr;
   logic [DataWidth-1:0] sampleReg;
   logic                 advance;
   logic                 lastAdvance;

`ifdef CLEAR_ON_RESET_EN
   logic [AddrWidth-1:0] clearAddr;
`endif

   // The output register accepts a new tap whenever it is empty or being consumed.
   assign advance     = (state == READ) && (!TapValid || TapReady);
   assign lastAdvance = advance && (tapCount == LastTap);

   // History index Head-k, wrapping below address 0 back to MaxAddr.
   always_comb begin
      readAddr = headPtr - tapCount;
      if (tapCount > headPtr)
         readAddr = AddrWidth'({1'b0, headPtr} + DepthExt - {1'b0, tapCount});
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
`ifdef CLEAR_ON_RESET_EN
         state <= CLEAR;
`else
         state <= IDLE;
`endif
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (SampleValid) nextState = WRITE;
         WRITE:   nextState = READ;
         READ:    if (lastAdvance) nextState = IDLE;
`ifdef CLEAR_ON_RESET_EN
         CLEAR:   if (clearAddr == LastAddr) nextState = IDLE;
`endif
         default: nextState = IDLE;
      endcase
   end

   // Write enable is gated by Reset so that reset itself never disturbs the RAM.
   always_comb begin
      SampleReady = 1'b0;
      Wr          = 1'b0;
      Addr        = headPtr;
      RAMIn       = '0;
      case (state)
         IDLE: begin
            SampleReady = 1'b1;
         end
         WRITE: begin
            Wr    = !Reset;
            RAMIn = sampleReg;
         end
         READ: begin
            Addr = readAddr;
         end
`ifdef CLEAR_ON_RESET_EN
         CLEAR: begin
            Wr   = !Reset;
            Addr = clearAddr;
         end
`endif
         default: begin
            SampleReady = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         headPtr   <= '0;
         tapCount  <= '0;
         sampleReg <= '0;
      end else begin
         if (state == IDLE && SampleValid)
            sampleReg <= SampleIn;
         if (state == WRITE)
            tapCount <= '0;
         else if (advance)
            tapCount <= tapCount + 1'b1;
         if (lastAdvance)
            headPtr <= (headPtr == LastAddr) ? '0 : headPtr + 1'b1;
      end
   end

   // Taps are held steady under backpressure and drop out once the last one is taken.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         TapValid <= 1'b0;
         TapLast  <= 1'b0;
         TapData  <= '0;
         TapIndex <= '0;
      end else if (advance) begin
         TapValid <= 1'b1;
         TapLast  <= (tapCount == LastTap);
         TapData  <= RAMOut;
         TapIndex <= TapWidth'(tapCount);
      end else if (TapValid && TapReady) begin
         TapValid <= 1'b0;
      end
   end

`ifdef CLEAR_ON_RESET_EN
   always_ff @(posedge Clk) begin
      if (Reset)
         clearAddr <= '0;
      else if (state == CLEAR)
         clearAddr <= clearAddr + 1'b1;
   end
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with a small RAM model (8 entries, 4 taps).
// Follows CLEAR_ON_RESET_EN when the macro is defined for the build.
module tb_fir_tap_sequencer;

   logic        Clk;
   logic        Reset;
   logic [15:0] SampleIn;
   logic        SampleValid;
   logic        SampleReady;
   logic [15:0] TapData;
   logic [1:0]  TapIndex;
   logic        TapValid;
   logic        TapLast;
   logic        TapReady;
   logic        Wr;
   logic [2:0]  Addr;
   logic [15:0] RAMIn;
   logic [15:0] RAMOut;

   logic [15:0] mem [0:7] = '{default: 16'h0};
   logic [15:0] modelHist [0:7];
   int          wrCount = 0;
   int          testsRun = 0;
   int          testsFailed = 0;
   int          expHead = 0;

   fir_tap_sequencer #(
      .AddrWidth(3),
      .DataWidth(16),
      .MaxAddr(7),
      .NumTaps(4),
      .TapWidth(2)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .SampleIn(SampleIn),
      .SampleValid(SampleValid),
      .SampleReady(SampleReady),
      .TapData(TapData),
      .TapIndex(TapIndex),
      .TapValid(TapValid),
      .TapLast(TapLast),
      .TapReady(TapReady),
      .Wr(Wr),
      .Addr(Addr),
      .RAMIn(RAMIn),
      .RAMOut(RAMOut)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      if (Wr) begin
         mem[Addr] <= RAMIn;
         wrCount   <= wrCount + 1;
      end
   end
   assign RAMOut = mem[Addr];

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Waits (bounded) for SampleReady, then presents one sample for a single edge.
   task automatic applyStimulus(input logic [15:0] value);
      int waited = 0;
      while (!SampleReady && waited < 50) begin
         tick();
         waited++;
      end
      if (!SampleReady)
         checkOutput("ready_timeout", {31'b0, SampleReady}, 32'd1);
      SampleIn    = value;
      SampleValid = 1'b1;
      tick();
      SampleValid = 1'b0;
   endtask

   task automatic runFrame(input logic [15:0] value, input int stallIdx, input int stallCycles, input bit holdNext);
      int wrBefore;
      int pos;
      applyStimulus(value);
      checkOutput("wr_en", {31'b0, Wr}, 32'd1);
      checkOutput("wr_addr", {29'b0, Addr}, expHead);
      checkOutput("wr_data", {16'b0, RAMIn}, {16'b0, value});
      checkOutput("ready_busy", {31'b0, SampleReady}, 32'd0);
      modelHist[expHead] = value;
      tick();
      wrBefore = wrCount;
      if (holdNext) begin
         SampleIn    = 16'h1234;
         SampleValid = 1'b1;
      end
      for (int j = 0; j < 4; j++) begin
         pos = (expHead + 8 - j) % 8;
         checkOutput("rd_addr", {29'b0, Addr}, pos);
         tick();
         checkOutput("tap_valid", {31'b0, TapValid}, 32'd1);
         checkOutput("tap_index", {30'b0, TapIndex}, j);
         checkOutput("tap_data", {16'b0, TapData}, {16'b0, modelHist[pos]});
         checkOutput("tap_last", {31'b0, TapLast}, (j == 3) ? 32'd1 : 32'd0);
         checkOutput("ready_phase", {31'b0, SampleReady}, (j == 3) ? 32'd1 : 32'd0);
         if (j == stallIdx) begin
            TapReady = 1'b0;
            repeat (stallCycles) begin
               tick();
               checkOutput("stall_valid", {31'b0, TapValid}, 32'd1);
               checkOutput("stall_index", {30'b0, TapIndex}, j);
               checkOutput("stall_data", {16'b0, TapData}, {16'b0, modelHist[pos]});
               checkOutput("stall_addr", {29'b0, Addr}, (expHead + 8 - j - 1) % 8);
            end
            TapReady = 1'b1;
         end
      end
      checkOutput("no_write_in_read", wrCount - wrBefore, 32'd0);
      expHead = (expHead + 1) % 8;
      if (!holdNext) begin
         tick();
         checkOutput("drain_valid", {31'b0, TapValid}, 32'd0);
         checkOutput("drain_ready", {31'b0, SampleReady}, 32'd1);
      end
   endtask

`ifdef CLEAR_ON_RESET_EN
   task automatic waitClear();
      for (int i = 0; i < 8; i++) begin
         checkOutput("clr_wr", {31'b0, Wr}, 32'd1);
         checkOutput("clr_addr", {29'b0, Addr}, i);
         checkOutput("clr_data", {16'b0, RAMIn}, 32'd0);
         checkOutput("clr_ready", {31'b0, SampleReady}, 32'd0);
         checkOutput("clr_tapvalid", {31'b0, TapValid}, 32'd0);
         tick();
      end
      checkOutput("clr_done_ready", {31'b0, SampleReady}, 32'd1);
      for (int i = 0; i < 8; i++)
         modelHist[i] = 16'h0;
   endtask
`endif

   initial begin
      for (int i = 0; i < 8; i++)
         modelHist[i] = 16'h0;
      Reset       = 1'b1;
      SampleIn    = 16'h0;
      SampleValid = 1'b0;
      TapReady    = 1'b1;
      tick();
      tick();

      checkOutput("rst_tapvalid", {31'b0, TapValid}, 32'd0);
      checkOutput("rst_taplast", {31'b0, TapLast}, 32'd0);
      checkOutput("rst_tapdata", {16'b0, TapData}, 32'd0);
      checkOutput("rst_tapindex", {30'b0, TapIndex}, 32'd0);
      checkOutput("rst_wr", {31'b0, Wr}, 32'd0);
      checkOutput("rst_addr", {29'b0, Addr}, 32'd0);
      checkOutput("rst_ramin", {16'b0, RAMIn}, 32'd0);
`ifdef CLEAR_ON_RESET_EN
      checkOutput("rst_ready", {31'b0, SampleReady}, 32'd0);
`else
      checkOutput("rst_ready", {31'b0, SampleReady}, 32'd1);
`endif
      Reset = 1'b0;
`ifdef CLEAR_ON_RESET_EN
      waitClear();
`endif

      // Samples 1..3: last frame yields 3,2,1,0.
      for (int s = 1; s <= 3; s++)
         runFrame(16'(s), -1, 0, 1'b0);

      // Samples 4..10: buffer wraps, sample 10 lands at address 1.
      for (int s = 4; s <= 10; s++)
         runFrame(16'(s), -1, 0, 1'b0);

      // Backpressure for three cycles while tap 1 is presented.
      runFrame(16'd11, 1, 3, 1'b0);

      // 0x1234 held valid during READ must wait for IDLE.
      runFrame(16'd12, -1, 0, 1'b1);
      runFrame(16'h1234, -1, 0, 1'b0);

      // Reset while tap 2 is presented.
      applyStimulus(16'h0055);
      modelHist[expHead] = 16'h0055;
      tick();
      tick();
      tick();
      tick();
      checkOutput("rst_pre_index", {30'b0, TapIndex}, 32'd2);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      checkOutput("midrst_tapvalid", {31'b0, TapValid}, 32'd0);
      checkOutput("midrst_tapindex", {30'b0, TapIndex}, 32'd0);
`ifdef CLEAR_ON_RESET_EN
      checkOutput("midrst_ready", {31'b0, SampleReady}, 32'd0);
`else
      checkOutput("midrst_ready", {31'b0, SampleReady}, 32'd1);
`endif
      expHead = 0;
`ifdef CLEAR_ON_RESET_EN
      waitClear();
`endif
      runFrame(16'h0077, -1, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
Upstream controller for the equalizer's sample-history RAM (single-port, synchronous write, asynchronous read).
- Accepts one audio sample per filter frame and writes it into a circular history buffer.
- Reads back the NumTaps most recent samples, newest first, and streams them with a tap index to the per-band MAC stage.
- Owns every RAM port: Wr, Addr and RAMIn are outputs; RAMOut is an input.

Parameters:
AddrWidth, 9, RAM address width
DataWidth, 16, sample width (signed two's complement; passed through unmodified)
MaxAddr, 511, highest RAM address; buffer depth is MaxAddr+1; must be <= 2^AddrWidth-1
NumTaps, 64, taps read per sample; legal range 1..MaxAddr+1
TapWidth, 6, TapIndex width; must satisfy 2^TapWidth >= NumTaps

Ports:
Clk  input  1  clock; all logic on the rising edge
Reset  input  1  synchronous, active-high reset
SampleIn  input  DataWidth  new audio sample
SampleValid  input  1  SampleIn is valid
SampleReady  output  1  block can accept a sample
TapData  output  DataWidth  history sample for the current tap
TapIndex  output  TapWidth  tap number; 0 = newest sample
TapValid  output  1  TapData and TapIndex are valid
TapLast  output  1  current tap is NumTaps-1
TapReady  input  1  MAC stage consumes the tap
Wr  output  1  RAM write enable
Addr  output  AddrWidth  RAM address
RAMIn  output  DataWidth  RAM write data
RAMOut  input  DataWidth  RAM asynchronous read data

Behaviour:
Clock and reset (already decided): one clock, Clk; reset is synchronous and active-high, on port Reset.

Reset values:
- SampleReady=1 (0 when CLEAR_ON_RESET_EN is defined).
- TapValid=0, TapLast=0, TapData=0, TapIndex=0.
- Wr=0, Addr=0, RAMIn=0.
- Head pointer=0.
- Reset wins over all other events, including mid-operation: the state returns to IDLE (or CLEAR), pending taps are dropped, and RAM contents are not touched by reset itself.

States:
- IDLE:
  - SampleReady=1, Wr=0, Addr=Head.
  - On SampleValid && SampleReady: latch SampleIn, then go to WRITE.
- WRITE (1 cycle):
  - SampleReady=0, Wr=1, Addr=Head, RAMIn=latched sample.
  - Set k=0, then go to READ.
- READ:
  - SampleReady=0, Wr=0, Addr=(Head-k) mod (MaxAddr+1); wrap from address 0 to MaxAddr.
  - Output register advances when !TapValid || TapReady. On advance: TapData<=RAMOut, TapIndex<=k, TapLast<=(k==NumTaps-1), TapValid<=1, k<=k+1.
  - On the advance with k==NumTaps-1: Head<=Head+1 (MaxAddr wraps to 0), then go to IDLE.
- Output drain: when the output register holds a valid tap, no new tap is loaded, and TapReady=1, TapValid drops to 0 at that edge.
- Stall: while TapValid && !TapReady, TapData, TapIndex, TapLast, Addr and k hold. No tap is skipped or duplicated.

Latency (no stalls): with the acceptance edge as E0,
- E0 to E1 is the WRITE cycle.
- Tap 0 is visible from E2; taps follow on consecutive cycles.
- TapLast is visible from E(NumTaps+1).
- SampleReady returns to 1 from E(NumTaps+1).

Boundary rules:
- SampleValid outside IDLE is ignored (SampleReady=0); upstream holds the sample until IDLE.
- The tap just written is read back as tap 0. The write is synchronous and completes before the READ cycle.
- If NumTaps=MaxAddr+1, every history entry is read exactly once per frame.

Optional Feature:
CLEAR_ON_RESET_EN
- Defined:
  - After reset deasserts, the block enters CLEAR for MaxAddr+1 cycles: Wr=1, RAMIn=0, Addr counts 0..MaxAddr.
  - SampleReady=0 and TapValid=0 throughout CLEAR; then go to IDLE.
  - Reset during CLEAR restarts CLEAR at address 0.
- Not defined:
  - No CLEAR state; the block goes straight to IDLE.
  - History before the first MaxAddr+1 samples is whatever the RAM held.

Test Plan:
1. Feature defined, AddrWidth=3, MaxAddr=7, NumTaps=4; reset, wait for clear; feed samples 1,2,3 -> taps after sample 3 are TapData 3,2,1,0 with TapIndex 0..3; TapLast only on index 3.
2. Same params; feed samples 1..10 -> sample 10 written at Addr 1; its taps are 10,9,8,7, read from Addr 1,0,7,6.
3. Backpressure: TapReady=0 for 3 cycles while TapIndex=1 is presented -> TapData, TapIndex and Addr are stable; the full sequence 0..3 is delivered exactly once.
4. SampleValid held high with value 0x1234 during READ -> SampleReady=0 and no write occurs; 0x1234 is written on the first WRITE after IDLE is reached.
5. Feature undefined; assert Reset for 1 cycle while TapIndex=2 is presented -> from the next edge: TapValid=0, SampleReady=1, the next sample is written at Addr 0.
6. Feature defined, MaxAddr=7; release reset -> 8 cycles of Wr=1, RAMIn=0, Addr 0..7 with SampleReady=0; SampleReady=1 on the 9th cycle.
